// File: rtl/draw_string_if.sv
// Handshake bundle between the string sequencer (master) and the 8-bit character drawer (slave).
interface draw_string_if #(
    parameter int CORDW = 16
);
    logic                    char_start;
    logic [7:0]              char_ucp;
    logic signed [CORDW-1:0] char_cx;
    logic signed [CORDW-1:0] char_cy;
    logic                    char_done;

    modport master (
        output char_start, char_ucp, char_cx, char_cy,
        input  char_done
    );

    modport slave (
        input  char_start, char_ucp, char_cx, char_cy,
        output char_done
    );
endinterface

// File: rtl/draw_string.sv
// String sequencer: walks a LEN-byte buffer, issuing one drawer request per printable byte.
// Optional automatic line wrap after LINE_CHARS glyphs when DRAW_STRING_WRAP_EN is defined.
module draw_string #(
    parameter int CORDW      = 16,
    parameter int WIDTH      = 8,
    parameter int HEIGHT     = 16,
    parameter int SPACING    = 0,
    parameter int LEN        = 32,
    parameter int LINE_CHARS = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [$clog2(LEN)-1:0]  wr_addr,
    input  logic [7:0]              wr_data,
    input  logic                    start,
    input  logic [$clog2(LEN):0]    len,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    draw_string_if.master           chr,
    output logic                    busy,
    output logic                    done
);
    localparam int AW = $clog2(LEN);
    localparam logic signed [CORDW-1:0] XStep = CORDW'(WIDTH + SPACING);
    localparam logic signed [CORDW-1:0] YStep = CORDW'(HEIGHT);

    if (LEN < 2 || (LEN & (LEN - 1)) != 0) begin : g_bad_len
        $error("LEN must be a power of two of at least 2");
    end
    if (LINE_CHARS < 1) begin : g_bad_line_chars
        $error("LINE_CHARS must be at least 1");
    end

    typedef enum logic [2:0] {
        StIdle, StRead, StFetch, StIssue, StWait, StNext, StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [AW:0]             idx_q, idx_d;
    logic [AW:0]             len_q, len_d;
    logic signed [CORDW-1:0] ox_q, ox_d;
    logic signed [CORDW-1:0] cx_q, cx_d;
    logic signed [CORDW-1:0] cy_q, cy_d;
    logic [7:0]              byte_q, byte_d;
    logic [7:0]              ucp_q, ucp_d;
    logic signed [CORDW-1:0] ccx_q, ccx_d;
    logic signed [CORDW-1:0] ccy_q, ccy_d;
    logic [7:0]              mem [LEN];
    logic [7:0]              rd_data_q;
`ifdef DRAW_STRING_WRAP_EN
    localparam int ColW = $clog2(LINE_CHARS + 1);
    logic [ColW-1:0]         col_q, col_d;
`endif

    // Buffer is not reset; writes are only accepted while idle.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) mem[wr_addr] <= wr_data;
        rd_data_q <= mem[idx_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            len_q   <= '0;
            ox_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            byte_q  <= '0;
            ucp_q   <= '0;
            ccx_q   <= '0;
            ccy_q   <= '0;
`ifdef DRAW_STRING_WRAP_EN
            col_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            ox_q    <= ox_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            byte_q  <= byte_d;
            ucp_q   <= ucp_d;
            ccx_q   <= ccx_d;
            ccy_q   <= ccy_d;
`ifdef DRAW_STRING_WRAP_EN
            col_q   <= col_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        ox_d    = ox_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        byte_d  = byte_q;
        ucp_d   = ucp_q;
        ccx_d   = ccx_q;
        ccy_d   = ccy_q;
`ifdef DRAW_STRING_WRAP_EN
        col_d   = col_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d  = len;
                    ox_d   = sx;
                    cx_d   = sx;
                    cy_d   = sy;
                    idx_d  = '0;
                    // Empty string passes through NEXT as a harmless newline so done lands on
                    // cycle 2, matching the final-character path.
                    byte_d = 8'h0A;
`ifdef DRAW_STRING_WRAP_EN
                    col_d  = '0;
`endif
                    state_d = (len == '0) ? StNext : StRead;
                end
            end
            StRead:  state_d = StFetch;
            StFetch: begin
                byte_d = rd_data_q;
                idx_d  = idx_q + 1'b1;
                if (rd_data_q == 8'h0A) begin
                    state_d = StNext;
                end else begin
                    ucp_d   = rd_data_q;
                    ccx_d   = cx_q;
                    ccy_d   = cy_q;
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait:  if (chr.char_done) state_d = StNext;
            StNext: begin
                if (byte_q == 8'h0A) begin
                    cx_d = ox_q;
                    cy_d = cy_q + YStep;
`ifdef DRAW_STRING_WRAP_EN
                    col_d = '0;
`endif
                end else begin
`ifdef DRAW_STRING_WRAP_EN
                    if (col_q + 1'b1 == ColW'(LINE_CHARS)) begin
                        cx_d  = ox_q;
                        cy_d  = cy_q + YStep;
                        col_d = '0;
                    end else begin
                        cx_d  = cx_q + XStep;
                        col_d = col_q + 1'b1;
                    end
`else
                    cx_d = cx_q + XStep;
`endif
                end
                state_d = (idx_q < len_q) ? StRead : StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign chr.char_start = (state_q == StIssue);
    assign chr.char_ucp   = ucp_q;
    assign chr.char_cx    = ccx_q;
    assign chr.char_cy    = ccy_q;
    assign busy           = (state_q != StIdle);
    assign done           = (state_q == StDone);
endmodule
